// File: rtl/dec_ascii_conv.sv
// rtl/dec_ascii_conv.sv - signed binary to fixed-width ASCII decimal string converter
//
// Converts a signed two's-complement value into a NUM_DIGITS+2 byte ASCII
// string (sign, digits, newline) using sequential double-dabble: one
// magnitude bit per cycle, then one formatting cycle.
//
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   start  level request; held high by the printer until done is seen
//   value  signed input, sampled once per conversion (LOAD cycle)
//   done   registered; high while the result is valid and start is still high
//   addr   string buffer read address
//   data   registered ASCII byte at addr, one cycle read latency
//
// Buffer layout: [NUM_DIGITS+1] sign, [NUM_DIGITS..1] digits (MSD first),
// [0] newline 0x0A, higher addresses read 0x00.
//
// Build option: define DEC_ASCII_LEADING_BLANK_EN to render leading zero
// digits as spaces (units digit always a numeral). Latency is unchanged.

module dec_ascii_conv #(
  parameter int VALUE_WIDTH = 32,
  parameter int NUM_DIGITS  = 10,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [VALUE_WIDTH-1:0] value,
  output logic                   done,
  input  logic [ADDR_WIDTH-1:0]  addr,
  output logic [7:0]             data
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(VALUE_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    FMT,
    DONE
  } state_t;

  state_t                 state;
  logic                   neg;
  logic [VALUE_WIDTH-1:0] mag;
  logic [BCD_W-1:0]       bcd;
  logic [CNT_W-1:0]       bit_cnt;
  logic [7:0]             sign_byte;
  logic [7:0]             digit_buf [NUM_DIGITS];

  logic [BCD_W-1:0]       bcd_adj;
  logic [7:0]             fmt_digit [NUM_DIGITS];
  logic [7:0]             rd_byte;

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift so
  // that it carries correctly into the next decimal digit.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Digit formatting. Index 0 of fmt_digit is the units digit.
`ifdef DEC_ASCII_LEADING_BLANK_EN
  logic leading;

  always_comb begin
    leading = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (leading && (bcd[4*i +: 4] == 4'd0) && (i != 0)) begin
        fmt_digit[i] = 8'h20;
      end else begin
        leading      = 1'b0;
        fmt_digit[i] = 8'h30 + {4'h0, bcd[4*i +: 4]};
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      fmt_digit[i] = 8'h30 + {4'h0, bcd[4*i +: 4]};
    end
  end
`endif

  // Buffer read mux; unmapped addresses read 0x00.
  always_comb begin
    rd_byte = 8'h00;
    if (addr == '0) begin
      rd_byte = 8'h0A;
    end
    if (addr == ADDR_WIDTH'(NUM_DIGITS + 1)) begin
      rd_byte = sign_byte;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (addr == ADDR_WIDTH'(i + 1)) begin
        rd_byte = digit_buf[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data <= 8'h00;
    end else begin
      data <= rd_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      neg       <= 1'b0;
      mag       <= '0;
      bcd       <= '0;
      bit_cnt   <= '0;
      sign_byte <= 8'h20;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_buf[i] <= 8'h20;
      end
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= LOAD;
          end
        end

        LOAD: begin
          neg     <= value[VALUE_WIDTH-1];
          // Unsigned negate: the most negative value maps to 2^(W-1).
          mag     <= value[VALUE_WIDTH-1] ? (~value + VALUE_WIDTH'(1)) : value;
          bcd     <= '0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end

        SHIFT: begin
          {bcd, mag} <= {bcd_adj[BCD_W-2:0], mag, 1'b0};
          bit_cnt    <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(VALUE_WIDTH - 1)) begin
            state <= FMT;
          end
        end

        FMT: begin
          sign_byte <= neg ? 8'h2D : 8'h20;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_buf[i] <= fmt_digit[i];
          end
          state <= DONE;
        end

        DONE: begin
          // done is always shown for at least one cycle, so a start pulse
          // that already dropped still produces a single-cycle done.
          if (done && !start) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end

        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dec_ascii_conv.sv
// tb/tb_dec_ascii_conv.sv - self-checking bench for dec_ascii_conv

module tb_dec_ascii_conv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        done;
  logic [3:0]  addr;
  logic [7:0]  data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  dec_ascii_conv #(
    .VALUE_WIDTH(32),
    .NUM_DIGITS (10),
    .ADDR_WIDTH (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .value(value),
    .done (done),
    .addr (addr),
    .data (data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Expected string byte at buffer index idx for value v, from decimal arithmetic.
  function automatic logic [7:0] exp_char(input logic [31:0] v, input int idx);
    longint sv, mag, p;
    sv  = longint'(signed'(v));
    mag = (sv < 0) ? -sv : sv;
    if (idx == 0) return 8'h0A;
    if (idx == 11) return (sv < 0) ? 8'h2D : 8'h20;
    if (idx > 11) return 8'h00;
    p = 1;
    for (int j = 0; j < idx - 1; j++) p = p * 10;
`ifdef DEC_ASCII_LEADING_BLANK_EN
    if (idx > 1 && mag < p) return 8'h20;
`endif
    return 8'h30 + 8'((mag / p) % 10);
  endfunction

  function automatic string pick(input string zero_pad, input string blank);
`ifdef DEC_ASCII_LEADING_BLANK_EN
    return blank;
`else
    return zero_pad;
`endif
  endfunction

  // Behavioural model: a conversion accepted at edge N captures value at
  // N+1, publishes the string at N+34 and raises done at N+35.
  logic [7:0]  m_buf [16];
  logic [7:0]  m_data;
  logic        m_done;
  logic        m_busy;
  int          m_rem;
  logic [31:0] m_val;

  always @(posedge clk) begin
    if (rst) begin
      m_data = 8'h00;
      m_done = 1'b0;
      m_busy = 1'b0;
      m_rem  = 0;
      for (int i = 0; i < 16; i++) m_buf[i] = (i == 0) ? 8'h0A : (i <= 11) ? 8'h20 : 8'h00;
    end else begin
      m_data = m_buf[addr];
      if (m_busy) begin
        m_rem--;
        if (m_rem == 34) m_val = value;
        if (m_rem == 1) for (int i = 0; i < 12; i++) m_buf[i] = exp_char(m_val, i);
        if (m_rem == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (m_done) begin
        if (!start) m_done = 1'b0;
      end else if (start) begin
        m_busy = 1'b1;
        m_rem  = 35;
      end
    end
  end

  // Per-cycle compare of DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    check("cyc_done", {31'b0, done}, {31'b0, m_done});
    check("cyc_data", {24'b0, data}, {24'b0, m_data});
  end

  task automatic wait_done(output int n);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    check("done_reached", {31'b0, done}, 32'd1);
  endtask

  // s holds buffer indices 11..1 in order; index 0 must be newline.
  task automatic read_str(input string name, input string s);
    logic [7:0] e;
    for (int i = 11; i >= 0; i--) begin
      @(negedge clk);
      addr = 4'(i);
      @(posedge clk);
      #1;
      e = (i == 0) ? 8'h0A : s[11-i];
      check(name, {24'b0, data}, {24'b0, e});
    end
  endtask

  task automatic convert(input string name, input logic [31:0] v, input string s);
    int n;
    @(negedge clk);
    value = v;
    start = 1'b1;
    wait_done(n);
    check({name, "_latency"}, n - 1, 32'd35);
    read_str(name, s);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_drop"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int         n;
    int         hi;
    logic [7:0] d;
    logic [31:0] v;
    bit         pulse;

    rst   = 1'b1;
    start = 1'b0;
    value = 32'h0;
    addr  = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_data", {24'b0, data}, 32'd0);
    rst = 1'b0;
    read_str("rst_buf", "           ");

    check("pin_a", {24'b0, exp_char(32'h51, 2)}, 32'h38);
    check("pin_b", {24'b0, exp_char(32'h80000000, 10)}, 32'h32);
    check("pin_c", {24'b0, exp_char(32'hFFFFFFFB, 11)}, 32'h2D);
    check("pin_d", {24'b0, exp_char(32'h0, 1)}, 32'h30);

    // 0x51 with start held past done.
    @(negedge clk);
    value = 32'h51;
    start = 1'b1;
    wait_done(n);
    check("v51_latency", n - 1, 32'd35);
    read_str("v51", pick(" 0000000081", "         81"));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("hold_done", {31'b0, done}, 32'd1);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("drop_done", {31'b0, done}, 32'd0);

    // New conversion; reads while busy return the old string.
    @(negedge clk);
    value = 32'h3E8;
    start = 1'b1;
    @(negedge clk);
    addr = 4'd2;
    @(posedge clk);
    #1;
    d = data;
    check("old_read", {24'b0, d}, 32'h38);
    wait_done(n);
    read_str("v3e8", pick(" 0000001000", "       1000"));
    @(negedge clk);
    start = 1'b0;

    convert("vm1", 32'hFFFFFFFF, pick("-0000000001", "-         1"));
    convert("vmin", 32'h80000000, "-2147483648");
    convert("vmax", 32'h7FFFFFFF, " 2147483647");
    convert("vzero", 32'h0, pick(" 0000000000", "          0"));
    convert("vm5", 32'hFFFFFFFB, pick("-0000000005", "-         5"));

    // One-cycle start pulse.
    @(negedge clk);
    value = 32'h7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    check("pulse_latency", n, 32'd35);
    hi = 1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (done) hi++;
      else break;
    end
    check("pulse_width", hi, 32'd1);
    read_str("v7", pick(" 0000000007", "          7"));

    // Reset in the middle of the shift phase.
    @(negedge clk);
    value = 32'h12345678;
    start = 1'b1;
    repeat (13) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_data", {24'b0, data}, 32'd0);
    rst = 1'b0;
    read_str("midrst_buf", "           ");
    convert("post_rst", 32'd12345, pick(" 0000012345", "      12345"));

    // Randomized conversions checked by the per-cycle model compare.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 5))
        0: v = $urandom_range(0, 20);
        1: v = -$urandom_range(0, 20);
        2: v = 32'h80000000;
        3: v = 32'h7FFFFFFF;
        default: v = $urandom;
      endcase
      pulse = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      value = v;
      start = 1'b1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        addr = 4'($urandom);
        if (k >= 1) value = $urandom;
        if (pulse) start = 1'b0;
      end
      @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        addr = 4'($urandom);
      end
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
